stage_id_pipe: RTL and testbench
================================

# stage_id_pipe

Registered, handshaked instruction-decode stage for the RV32I/RV64I core pipeline, sitting between IF/ID and EX. It decodes OP-IMM, OP, LUI, AUIPC, LOAD and STORE, generates sign-extended immediates, and reads the regfile. It forwards results from EX and MEM and detects load-use hazards, inserting a bubble when one occurs. Outputs are held in an ID/EX register with valid/ready flow control and synchronous flush.

## Interface
- XLEN, 32: data width, 32 or 64; immediates sign-extend to XLEN.
- ALUOP_W, 8: aluop field width.
- ALUSEL_W, 3: alusel field width.
- FWD_EN, 1: 1 enables EX/MEM forwarding; 0 uses regfile data only. Load-use stall stays active in both settings.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- in_valid / in_ready  in/out  1  instruction handshake from IF/ID.
- in_pc  in  XLEN  PC of in_inst.
- in_inst  in  32  instruction word.
- reg1_read_o, reg2_read_o  out  1  regfile read enables.
- reg1_addr_o, reg2_addr_o  out  5  regfile read addresses (rs1, rs2).
- reg1_data_i, reg2_data_i  in  XLEN  regfile read data; combinational, same cycle.
- ex_wreg_i, ex_is_load_i  in  1  EX-stage write enable and load flag.
- ex_wd_i  in  5  EX-stage destination register.
- ex_wdata_i  in  XLEN  EX-stage result.
- mem_wreg_i  in  1  MEM-stage write enable.
- mem_wd_i  in  5  MEM-stage destination register.
- mem_wdata_i  in  XLEN  MEM-stage result.
- flush_i  in  1  kill the ID/EX contents and the current input.
- out_valid / out_ready  out/in  1  handshake to EX.
- out_pc, out_reg1, out_reg2, out_imm  out  XLEN  registered PC, operands, immediate.
- out_aluop  out  ALUOP_W.
- out_alusel  out  ALUSEL_W.
- out_wd  out  5  destination register.
- out_wreg, out_illegal  out  1  destination write enable; illegal-instruction flag.

## Operation
**Decode**
- Immediates:
  - I-type = inst[31:20].
  - S-type = {inst[31:25], inst[11:7]}.
  - U-type = {inst[31:12], 12'b0}.
  - All are sign-extended from bit 31.
- aluop codes: ADD=01, SUB=02, SLL=03, SLT=04, SLTU=05, XOR=06, SRL=07, SRA=08, OR=09, AND=0A, LUI=0B, AUIPC=0C, LOAD=0D, STORE=0E, NOP=00.
- alusel codes: NOP=0, LOGIC=1, SHIFT=2, ARITH=3, MOVE=4, LDST=5.
- Operand and write rules per format:
  - OP: reg1 = rs1, reg2 = rs2, wreg = 1.
  - OP-IMM: reg1 = rs1, reg2 = imm, wreg = 1. Shift-immediates use shamt = inst[24:20] when XLEN=32 and inst[25:20] when XLEN=64.
  - LUI: reg1 = 0, reg2 = imm, wreg = 1.
  - AUIPC: reg1 = pc, reg2 = imm, wreg = 1.
  - LOAD: reg1 = rs1, reg2 = 0, out_imm = I-imm, wreg = 1.
  - STORE: reg1 = rs1, reg2 = rs2, out_imm = S-imm, wreg = 0.
- Illegal instruction (unknown opcode or bad funct7): out_illegal = 1, aluop = NOP, wreg = 0, read enables = 0.
- A destination of rd = x0 forces wreg = 0.

**Operand select** (only for sources whose read enable is set; any x0 source reads as 0)
- EX hit: ex_wreg_i & ex_wd_i == rs & rs != 0 & !ex_is_load_i, with FWD_EN=1 → take ex_wdata_i.
- Otherwise MEM hit: same rule using the mem_* signals → take mem_wdata_i.
- Otherwise take regfile data.

**Load-use hazard**
- Condition: ex_is_load_i & ex_wreg_i & ex_wd_i != 0 & ex_wd_i matches a used source.
- While it holds: in_ready = 0, and a bubble (out_valid = 0) is loaded whenever the ID/EX register advances.

**Output register control**
- States are EMPTY (out_valid = 0) and FULL (out_valid = 1).
- advance = !out_valid | out_ready.
- in_ready = advance & !hazard.
- On advance: the register loads the decoded instruction if in_valid & in_ready, otherwise a bubble.
- In FULL with !out_ready: all out_* fields hold stable.

**Flush**
- flush_i takes priority over every other condition.
- Next edge: out_valid = 0.
- in_ready = 1 during flush; the presented instruction is consumed and discarded.

## Timing
- Latency: an instruction accepted at edge N appears with out_valid = 1 after edge N.
- Throughput: 1 instruction/cycle when out_ready = 1 and no hazard.
- Reset (rst = 0, asynchronous, including mid-transfer):
  - out_valid = 0, out_wreg = 0, out_illegal = 0.
  - out_aluop = NOP, out_alusel = NOP.
  - out_pc, out_reg1, out_reg2, out_imm, out_wd = 0.
- Combinational outputs during reset: in_ready = 0, read enables = 0, read addresses = 0.
- Release: first acceptance is on the first edge after rst returns to 1.
- Load-use stall: exactly one bubble per load, since the load leaves EX on the next edge.
- Simultaneous hazard and !out_ready: the register holds; no bubble is inserted until advance.
- Fields are updated only on valid acceptance, so they never change while out_valid & !out_ready.

## Test plan
- **Basic decode:** ADDI x1,x0,5 (0x00500093), out_ready = 1 → one cycle later: out_valid = 1, aluop = 01, alusel = 3, reg1 = 0, reg2 = 5, wd = 1, wreg = 1.
- **Forwarding:** ADD x3,x1,x2 (0x002081B3) with ex_wd = 1, ex_wdata = 0x10; mem_wd = 2, mem_wdata = 0x20; regfile returns 0xFF → reg1 = 0x10, reg2 = 0x20. Repeat with FWD_EN = 0 → both operands = 0xFF.
- **Load-use:** ex_is_load = 1, ex_wd = 1, ex_wreg = 1, ADD x3,x1,x2 presented → in_ready = 0 for one cycle and out_valid = 0. Next cycle (EX now has no load): ADD is accepted.
- **Backpressure:** stream 4 ADDIs with out_ready low for 3 cycles → outputs held stable, in_ready = 0, no instruction lost or duplicated, order preserved.
- **Flush:** flush_i pulsed while FULL with out_ready = 0 → out_valid = 0 next cycle; the presented instruction does not appear.
- **Illegal and reset:** 0xFFFFFFFF presented → out_illegal = 1, wreg = 0. Assert rst mid-stream → all outputs reach reset values immediately.

Source files
------------

// File: rtl/stage_id_pipe.sv
// Instruction-decode stage: decodes the integer ALU/load/store subset, selects forwarded
// operands, stalls on load-use and holds the result in a valid/ready ID/EX register.
module stage_id_pipe #(
    parameter int XLEN     = 32,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int FWD_EN   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [31:0]         in_inst,
    output logic                reg1_read_o,
    output logic                reg2_read_o,
    output logic [4:0]          reg1_addr_o,
    output logic [4:0]          reg2_addr_o,
    input  logic [XLEN-1:0]     reg1_data_i,
    input  logic [XLEN-1:0]     reg2_data_i,
    input  logic                ex_wreg_i,
    input  logic                ex_is_load_i,
    input  logic [4:0]          ex_wd_i,
    input  logic [XLEN-1:0]     ex_wdata_i,
    input  logic                mem_wreg_i,
    input  logic [4:0]          mem_wd_i,
    input  logic [XLEN-1:0]     mem_wdata_i,
    input  logic                flush_i,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [XLEN-1:0]     out_reg1,
    output logic [XLEN-1:0]     out_reg2,
    output logic [XLEN-1:0]     out_imm,
    output logic [ALUOP_W-1:0]  out_aluop,
    output logic [ALUSEL_W-1:0] out_alusel,
    output logic [4:0]          out_wd,
    output logic                out_wreg,
    output logic                out_illegal,
    output logic                dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and the producer holds its payload until the transfer.

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [ALUOP_W-1:0] OP_NOP   = ALUOP_W'(8'h00);
    localparam logic [ALUOP_W-1:0] OP_ADD   = ALUOP_W'(8'h01);
    localparam logic [ALUOP_W-1:0] OP_SUB   = ALUOP_W'(8'h02);
    localparam logic [ALUOP_W-1:0] OP_SLL   = ALUOP_W'(8'h03);
    localparam logic [ALUOP_W-1:0] OP_SLT   = ALUOP_W'(8'h04);
    localparam logic [ALUOP_W-1:0] OP_SLTU  = ALUOP_W'(8'h05);
    localparam logic [ALUOP_W-1:0] OP_XOR   = ALUOP_W'(8'h06);
    localparam logic [ALUOP_W-1:0] OP_SRL   = ALUOP_W'(8'h07);
    localparam logic [ALUOP_W-1:0] OP_SRA   = ALUOP_W'(8'h08);
    localparam logic [ALUOP_W-1:0] OP_OR    = ALUOP_W'(8'h09);
    localparam logic [ALUOP_W-1:0] OP_AND   = ALUOP_W'(8'h0A);
    localparam logic [ALUOP_W-1:0] OP_LUI   = ALUOP_W'(8'h0B);
    localparam logic [ALUOP_W-1:0] OP_AUIPC = ALUOP_W'(8'h0C);
    localparam logic [ALUOP_W-1:0] OP_LOAD  = ALUOP_W'(8'h0D);
    localparam logic [ALUOP_W-1:0] OP_STORE = ALUOP_W'(8'h0E);

    localparam logic [ALUSEL_W-1:0] SEL_NOP   = ALUSEL_W'(3'd0);
    localparam logic [ALUSEL_W-1:0] SEL_LOGIC = ALUSEL_W'(3'd1);
    localparam logic [ALUSEL_W-1:0] SEL_SHIFT = ALUSEL_W'(3'd2);
    localparam logic [ALUSEL_W-1:0] SEL_ARITH = ALUSEL_W'(3'd3);
    localparam logic [ALUSEL_W-1:0] SEL_MOVE  = ALUSEL_W'(3'd4);
    localparam logic [ALUSEL_W-1:0] SEL_LDST  = ALUSEL_W'(3'd5);

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_shamt;
    logic            w_sll_ok;
    logic            w_sr_ok;

    assign w_opcode = in_inst[6:0];
    assign w_rd     = in_inst[11:7];
    assign w_funct3 = in_inst[14:12];
    assign w_rs1    = in_inst[19:15];
    assign w_rs2    = in_inst[24:20];
    assign w_funct7 = in_inst[31:25];
    assign w_imm_i  = XLEN'($signed(in_inst[31:20]));
    assign w_imm_s  = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
    assign w_imm_u  = XLEN'($signed({in_inst[31:12], 12'b0}));

    // RV64 shift-immediates carry a 6-bit shamt, so funct7 shrinks to funct6 there.
    assign w_shamt  = (XLEN == 64) ? XLEN'(in_inst[25:20]) : XLEN'(in_inst[24:20]);
    assign w_sll_ok = (XLEN == 64) ? (in_inst[31:26] == 6'b0) : (in_inst[31:25] == 7'b0);
    assign w_sr_ok  = (XLEN == 64) ? ({in_inst[31], in_inst[29:26]} == 5'b0)
                                   : ({in_inst[31], in_inst[29:25]} == 6'b0);

    logic                w_illegal;
    logic                w_re1;
    logic                w_re2;
    logic                w_wreg;
    logic                w_op1_pc;
    logic                w_op2_imm;
    logic [4:0]          w_wd;
    logic [XLEN-1:0]     w_imm;
    logic [XLEN-1:0]     w_op2_immval;
    logic [ALUOP_W-1:0]  w_aluop;
    logic [ALUSEL_W-1:0] w_alusel;

    always_comb begin
        w_illegal    = 1'b0;
        w_re1        = 1'b0;
        w_re2        = 1'b0;
        w_wreg       = 1'b0;
        w_op1_pc     = 1'b0;
        w_op2_imm    = 1'b0;
        w_wd         = w_rd;
        w_imm        = '0;
        w_op2_immval = '0;
        w_aluop      = OP_NOP;
        w_alusel     = SEL_NOP;
        case (w_opcode)
            OPC_OP: begin
                w_re1  = 1'b1;
                w_re2  = 1'b1;
                w_wreg = 1'b1;
                if (w_funct7 == 7'b0000000) begin
                    case (w_funct3)
                        3'b000:  begin w_aluop = OP_ADD;  w_alusel = SEL_ARITH; end
                        3'b001:  begin w_aluop = OP_SLL;  w_alusel = SEL_SHIFT; end
                        3'b010:  begin w_aluop = OP_SLT;  w_alusel = SEL_ARITH; end
                        3'b011:  begin w_aluop = OP_SLTU; w_alusel = SEL_ARITH; end
                        3'b100:  begin w_aluop = OP_XOR;  w_alusel = SEL_LOGIC; end
                        3'b101:  begin w_aluop = OP_SRL;  w_alusel = SEL_SHIFT; end
                        3'b110:  begin w_aluop = OP_OR;   w_alusel = SEL_LOGIC; end
                        default: begin w_aluop = OP_AND;  w_alusel = SEL_LOGIC; end
                    endcase
                end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
                    w_aluop  = OP_SUB;
                    w_alusel = SEL_ARITH;
                end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b101) begin
                    w_aluop  = OP_SRA;
                    w_alusel = SEL_SHIFT;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OPC_OPIMM: begin
                w_re1        = 1'b1;
                w_wreg       = 1'b1;
                w_op2_imm    = 1'b1;
                w_imm        = w_imm_i;
                w_op2_immval = w_imm_i;
                case (w_funct3)
                    3'b000:  begin w_aluop = OP_ADD;  w_alusel = SEL_ARITH; end
                    3'b010:  begin w_aluop = OP_SLT;  w_alusel = SEL_ARITH; end
                    3'b011:  begin w_aluop = OP_SLTU; w_alusel = SEL_ARITH; end
                    3'b100:  begin w_aluop = OP_XOR;  w_alusel = SEL_LOGIC; end
                    3'b110:  begin w_aluop = OP_OR;   w_alusel = SEL_LOGIC; end
                    3'b111:  begin w_aluop = OP_AND;  w_alusel = SEL_LOGIC; end
                    3'b001: begin
                        w_aluop      = OP_SLL;
                        w_alusel     = SEL_SHIFT;
                        w_op2_immval = w_shamt;
                        w_illegal    = !w_sll_ok;
                    end
                    default: begin
                        w_aluop      = in_inst[30] ? OP_SRA : OP_SRL;
                        w_alusel     = SEL_SHIFT;
                        w_op2_immval = w_shamt;
                        w_illegal    = !w_sr_ok;
                    end
                endcase
            end
            OPC_LUI: begin
                w_wreg = 1'b1; w_op2_imm = 1'b1; w_imm = w_imm_u; w_op2_immval = w_imm_u;
                w_aluop = OP_LUI; w_alusel = SEL_MOVE;
            end
            OPC_AUIPC: begin
                w_wreg = 1'b1; w_op1_pc = 1'b1; w_op2_imm = 1'b1;
                w_imm = w_imm_u; w_op2_immval = w_imm_u;
                w_aluop = OP_AUIPC; w_alusel = SEL_MOVE;
            end
            OPC_LOAD: begin
                w_re1 = 1'b1; w_wreg = 1'b1; w_imm = w_imm_i;
                w_aluop = OP_LOAD; w_alusel = SEL_LDST;
            end
            OPC_STORE: begin
                w_re1 = 1'b1; w_re2 = 1'b1; w_wd = 5'd0; w_imm = w_imm_s;
                w_aluop = OP_STORE; w_alusel = SEL_LDST;
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_re1     = 1'b0;
            w_re2     = 1'b0;
            w_wreg    = 1'b0;
            w_op1_pc  = 1'b0;
            w_op2_imm = 1'b0;
            w_wd      = 5'd0;
            w_imm     = '0;
            w_aluop   = OP_NOP;
            w_alusel  = SEL_NOP;
        end
        if (w_rd == 5'd0) begin
            w_wreg = 1'b0;
        end
    end

    assign reg1_read_o = rst & w_re1;
    assign reg2_read_o = rst & w_re2;
    assign reg1_addr_o = reg1_read_o ? w_rs1 : 5'd0;
    assign reg2_addr_o = reg2_read_o ? w_rs2 : 5'd0;

    // A load in EX has no data yet, so it is excluded from forwarding and stalls instead.
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    always_comb begin
        w_rs1_val = reg1_data_i;
        if (w_rs1 == 5'd0)
            w_rs1_val = '0;
        else if (FWD_EN != 0 && ex_wreg_i && ex_wd_i == w_rs1 && !ex_is_load_i)
            w_rs1_val = ex_wdata_i;
        else if (FWD_EN != 0 && mem_wreg_i && mem_wd_i == w_rs1)
            w_rs1_val = mem_wdata_i;
        w_rs2_val = reg2_data_i;
        if (w_rs2 == 5'd0)
            w_rs2_val = '0;
        else if (FWD_EN != 0 && ex_wreg_i && ex_wd_i == w_rs2 && !ex_is_load_i)
            w_rs2_val = ex_wdata_i;
        else if (FWD_EN != 0 && mem_wreg_i && mem_wd_i == w_rs2)
            w_rs2_val = mem_wdata_i;
    end

    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    assign w_op1 = w_re1 ? w_rs1_val : (w_op1_pc ? in_pc : '0);
    assign w_op2 = w_re2 ? w_rs2_val : (w_op2_imm ? w_op2_immval : '0);

    logic w_hazard;
    assign w_hazard = ex_is_load_i & ex_wreg_i & (ex_wd_i != 5'd0) &
                      ((reg1_read_o & (ex_wd_i == w_rs1)) | (reg2_read_o & (ex_wd_i == w_rs2)));

    logic w_advance;
    logic w_accept;
    always_comb begin
        w_advance   = (r_state == ST_EMPTY) | out_ready;
        in_ready    = rst & (flush_i | (w_advance & !w_hazard));
        w_accept    = in_valid & in_ready & !flush_i;
        w_state_nxt = r_state;
        if (flush_i)
            w_state_nxt = ST_EMPTY;
        else if (w_advance)
            w_state_nxt = w_accept ? ST_FULL : ST_EMPTY;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= ST_EMPTY;
        else
            r_state <= w_state_nxt;
    end

    // Payload only moves on acceptance, so bubbles and flushes leave it untouched.
    logic [XLEN-1:0]     r_pc;
    logic [XLEN-1:0]     r_reg1;
    logic [XLEN-1:0]     r_reg2;
    logic [XLEN-1:0]     r_imm;
    logic [ALUOP_W-1:0]  r_aluop;
    logic [ALUSEL_W-1:0] r_alusel;
    logic [4:0]          r_wd;
    logic                r_wreg;
    logic                r_illegal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc      <= '0;
            r_reg1    <= '0;
            r_reg2    <= '0;
            r_imm     <= '0;
            r_aluop   <= OP_NOP;
            r_alusel  <= SEL_NOP;
            r_wd      <= 5'd0;
            r_wreg    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_pc      <= in_pc;
            r_reg1    <= w_op1;
            r_reg2    <= w_op2;
            r_imm     <= w_imm;
            r_aluop   <= w_aluop;
            r_alusel  <= w_alusel;
            r_wd      <= w_wd;
            r_wreg    <= w_wreg;
            r_illegal <= w_illegal;
        end
    end

    assign out_valid   = (r_state == ST_FULL);
    assign dbg_state_o = r_state;
    assign out_pc      = r_pc;
    assign out_reg1    = r_reg1;
    assign out_reg2    = r_reg2;
    assign out_imm     = r_imm;
    assign out_aluop   = r_aluop;
    assign out_alusel  = r_alusel;
    assign out_wd      = r_wd;
    assign out_wreg    = r_wreg;
    assign out_illegal = r_illegal;

endmodule

// File: tb/tb_stage_id_pipe.sv
// Scoreboard bench for stage_id_pipe: directed decode table, forwarding, load-use,
// backpressure, flush, illegal and asynchronous reset cases.
module tb_stage_id_pipe;

  localparam int EW = 146;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic        ex_wreg_i, ex_is_load_i, mem_wreg_i, flush_i;
  logic [4:0]  ex_wd_i, mem_wd_i;
  logic [31:0] ex_wdata_i, mem_wdata_i;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_reg1, out_reg2, out_imm;
  logic [7:0]  out_aluop;
  logic [2:0]  out_alusel;
  logic [4:0]  out_wd;
  logic        out_wreg, out_illegal, dbg_state_o;

  logic        nf_in_ready, nf_reg1_read_o, nf_reg2_read_o;
  logic [4:0]  nf_reg1_addr_o, nf_reg2_addr_o;
  logic        nf_out_valid;
  logic [31:0] nf_out_pc, nf_out_reg1, nf_out_reg2, nf_out_imm;
  logic [7:0]  nf_out_aluop;
  logic [2:0]  nf_out_alusel;
  logic [4:0]  nf_out_wd;
  logic        nf_out_wreg, nf_out_illegal, nf_dbg_state_o;

  logic [EW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  stage_id_pipe #(.XLEN(32), .ALUOP_W(8), .ALUSEL_W(3), .FWD_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o), .reg1_data_i(reg1_data_i),
    .reg2_data_i(reg2_data_i), .ex_wreg_i(ex_wreg_i), .ex_is_load_i(ex_is_load_i),
    .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i),
    .mem_wdata_i(mem_wdata_i), .flush_i(flush_i), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_reg1(out_reg1), .out_reg2(out_reg2), .out_imm(out_imm),
    .out_aluop(out_aluop), .out_alusel(out_alusel), .out_wd(out_wd), .out_wreg(out_wreg),
    .out_illegal(out_illegal), .dbg_state_o(dbg_state_o)
  );

  stage_id_pipe #(.XLEN(32), .ALUOP_W(8), .ALUSEL_W(3), .FWD_EN(0)) dut_nf (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nf_in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .reg1_read_o(nf_reg1_read_o), .reg2_read_o(nf_reg2_read_o),
    .reg1_addr_o(nf_reg1_addr_o), .reg2_addr_o(nf_reg2_addr_o), .reg1_data_i(reg1_data_i),
    .reg2_data_i(reg2_data_i), .ex_wreg_i(ex_wreg_i), .ex_is_load_i(ex_is_load_i),
    .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i),
    .mem_wdata_i(mem_wdata_i), .flush_i(flush_i), .out_valid(nf_out_valid),
    .out_ready(out_ready), .out_pc(nf_out_pc), .out_reg1(nf_out_reg1),
    .out_reg2(nf_out_reg2), .out_imm(nf_out_imm), .out_aluop(nf_out_aluop),
    .out_alusel(nf_out_alusel), .out_wd(nf_out_wd), .out_wreg(nf_out_wreg),
    .out_illegal(nf_out_illegal), .dbg_state_o(nf_dbg_state_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] pk(input logic il, input logic wr, input logic [4:0] wd,
                                       input logic [7:0] op, input logic [2:0] sel,
                                       input logic [31:0] pc, input logic [31:0] r1,
                                       input logic [31:0] r2, input logic [31:0] im);
    return {il, wr, wd, op, sel, pc, r1, r2, im};
  endfunction

  function automatic logic [EW-1:0] pack_out();
    return pk(out_illegal, out_wreg, out_wd, out_aluop, out_alusel, out_pc, out_reg1,
              out_reg2, out_imm);
  endfunction

  function automatic logic [31:0] addi_x0(input int n);
    logic [11:0] imm;
    logic [4:0]  rd;
    imm = 12'(n);
    rd  = 5'(n);
    return {imm, 5'd0, 3'b000, rd, 7'h13};
  endfunction

  // scoreboard monitor: samples one time unit before each rising edge
  always begin
    logic [EW-1:0] e;
    @(negedge clk);
    #4;
    if (rst === 1'b1 && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_out", pack_out(), '0);
      end else begin
        e = exp_q.pop_front();
        check_val("out_fields", pack_out(), e);
      end
    end
  end

  // driver: called at a falling edge, returns at a falling edge
  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input logic [EW-1:0] exp,
                      input int budget);
    bit accepted = 0;
    int n = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    while (!accepted && n < budget) begin
      #1;
      if (in_ready) begin
        exp_q.push_back(exp);
        accepted = 1;
      end
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    if (!accepted) check_val("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [EW-1:0] snap;
    rst = 1'b0; in_valid = 1'b1; in_pc = 32'h0; in_inst = 32'h002081B3;
    reg1_data_i = 32'h111; reg2_data_i = 32'h222;
    ex_wreg_i = 0; ex_is_load_i = 0; ex_wd_i = 0; ex_wdata_i = 0;
    mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0; flush_i = 0; out_ready = 1'b1;

    // reset state
    idle(2);
    #1;
    check_val("rst_fields", pack_out(), '0);
    check_val("rst_valid", out_valid, 0);
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_rd_port", {reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o}, 0);
    @(negedge clk);
    rst = 1'b1;

    // basic decode table; first acceptance on the first edge after release
    send(32'h00500093, 32'h100, pk(0, 1, 1, 8'h01, 3, 32'h100, 0, 5, 5), 1);
    #1 check_val("latency_valid", out_valid, 1);
    @(negedge clk);
    send(32'h407302B3, 32'h104, pk(0, 1, 5, 8'h02, 3, 32'h104, 32'h111, 32'h222, 0), 2);
    send(32'hABCDE137, 32'h108, pk(0, 1, 2, 8'h0B, 4, 32'h108, 0, 32'hABCDE000, 32'hABCDE000), 2);
    send(32'h12345217, 32'h1000, pk(0, 1, 4, 8'h0C, 4, 32'h1000, 32'h1000, 32'h12345000, 32'h12345000), 2);
    send(32'hFFC0A303, 32'h10C, pk(0, 1, 6, 8'h0D, 5, 32'h10C, 32'h111, 0, 32'hFFFFFFFC), 2);
    send(32'hFE20AC23, 32'h110, pk(0, 0, 0, 8'h0E, 5, 32'h110, 32'h111, 32'h222, 32'hFFFFFFF8), 2);
    send(32'h4041D393, 32'h114, pk(0, 1, 7, 8'h08, 2, 32'h114, 32'h111, 4, 32'h404), 2);
    send(32'h00100013, 32'h118, pk(0, 0, 0, 8'h01, 3, 32'h118, 0, 1, 1), 2);
    send(32'hFFFFFFFF, 32'h11C, pk(1, 0, 0, 8'h00, 0, 32'h11C, 0, 0, 0), 2);
    send(32'h022081B3, 32'h120, pk(1, 0, 0, 8'h00, 0, 32'h120, 0, 0, 0), 2);

    // forwarding: EX for rs1, MEM for rs2, regfile 0xFF
    reg1_data_i = 32'hFF; reg2_data_i = 32'hFF;
    ex_wreg_i = 1; ex_wd_i = 1; ex_wdata_i = 32'h10;
    mem_wreg_i = 1; mem_wd_i = 2; mem_wdata_i = 32'h20;
    send(32'h002081B3, 32'h200, pk(0, 1, 3, 8'h01, 3, 32'h200, 32'h10, 32'h20, 0), 2);
    #1;
    check_val("nofwd_reg1", nf_out_reg1, 32'hFF);
    check_val("nofwd_reg2", nf_out_reg2, 32'hFF);
    @(negedge clk);
    mem_wd_i = 1;
    send(32'h002081B3, 32'h204, pk(0, 1, 3, 8'h01, 3, 32'h204, 32'h10, 32'hFF, 0), 2);
    ex_wreg_i = 0; ex_wd_i = 0; ex_wdata_i = 0; mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0;
    reg1_data_i = 32'h111; reg2_data_i = 32'h222;

    // load-use: one bubble, then acceptance once the load has left EX
    ex_is_load_i = 1; ex_wreg_i = 1; ex_wd_i = 1;
    in_valid = 1; in_inst = 32'h002081B3; in_pc = 32'h300;
    #1 check_val("lu_in_ready", in_ready, 0);
    @(negedge clk);
    #1 check_val("lu_bubble", out_valid, 0);
    @(negedge clk);
    ex_is_load_i = 0; ex_wreg_i = 0; ex_wd_i = 0;
    send(32'h002081B3, 32'h300, pk(0, 1, 3, 8'h01, 3, 32'h300, 32'h111, 32'h222, 0), 1);
    idle(1);

    // backpressure: four ADDIs, out_ready low for three cycles
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++)
          send(addi_x0(i), 32'h400 + 32'(4 * i), pk(0, 1, 5'(i), 8'h01, 3, 32'h400 + 32'(4 * i), 0, 32'(i), 32'(i)), 10);
      end
      begin
        @(negedge clk);
        #1;
        snap = pack_out();
        check_val("bp_valid", out_valid, 1);
        for (int k = 0; k < 3; k++) begin
          check_val("bp_in_ready", in_ready, 0);
          check_val("bp_hold", pack_out(), snap);
          if (k < 2) begin
            @(negedge clk);
            #1;
          end
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    idle(2);
    check_val("bp_drain", exp_q.size(), 0);

    // flush while FULL and stalled
    out_ready = 1'b0;
    send(addi_x0(9), 32'h500, pk(0, 1, 9, 8'h01, 3, 32'h500, 0, 9, 9), 2);
    in_valid = 1; in_inst = addi_x0(10); in_pc = 32'h504; flush_i = 1;
    #1 check_val("fl_in_ready", in_ready, 1);
    exp_q.delete();
    @(negedge clk);
    flush_i = 0; in_valid = 0;
    #1 check_val("fl_valid", out_valid, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1 check_val("fl_gone", out_valid, 0);
    end
    @(negedge clk);

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    send(addi_x0(11), 32'h600, pk(0, 1, 11, 8'h01, 3, 32'h600, 0, 11, 11), 2);
    in_valid = 1; in_inst = addi_x0(12); in_pc = 32'h604;
    #2 rst = 1'b0;
    #1;
    check_val("rst2_fields", pack_out(), '0);
    check_val("rst2_valid", out_valid, 0);
    check_val("rst2_in_ready", in_ready, 0);
    check_val("rst2_rd_port", {reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o}, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1;
    send(addi_x0(12), 32'h604, pk(0, 1, 12, 8'h01, 3, 32'h604, 0, 12, 12), 1);
    idle(3);
    check_val("final_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
